// File: rtl/mem_responder_if.sv
// Instruction- and data-memory bus between the cpu (master) and the memory
// responder (slave).
interface mem_responder_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        imem_stall;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_stall;

    modport master (
        output imem_addr, imem_rmask, imem_stall,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, dmem_stall,
        input  imem_rdata, imem_resp, dmem_rdata, dmem_resp
    );

    modport slave (
        input  imem_addr, imem_rmask, imem_stall,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, dmem_stall,
        output imem_rdata, imem_resp, dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_responder.sv
// Dual-port memory responder: shared word array, fixed stallable latency,
// byte-masked reads and writes, one-cycle resp pulse per request.
module mem_responder_port #(
    parameter int          AW      = 14,
    parameter int unsigned LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic          stall_i,
    input  logic [AW-1:0] idx_i,
    input  logic          ok_i,
    input  logic [3:0]    rmask_i,
    output logic          accept_o,
    output logic          load_o,
    output logic          resp_o,
    output logic [AW-1:0] idx_o,
    output logic          ok_o,
    output logic [3:0]    rmask_o
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic          ok_q;
    logic [3:0]    rmask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ok_q    <= 1'b0;
            rmask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_o) begin
                idx_q   <= idx_i;
                ok_q    <= ok_i;
                rmask_q <= rmask_i;
            end
        end
    end

    // load_o marks the edge that enters RESP; the read is captured on it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_o   = 1'b0;
        accept_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    accept_o = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        load_o  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!stall_i) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_RESP;
                        load_o  = 1'b1;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // In IDLE the live request is used (LATENCY==1 reads on the accept edge).
    assign resp_o  = (state_q == S_RESP);
    assign idx_o   = (state_q == S_IDLE) ? idx_i   : idx_q;
    assign ok_o    = (state_q == S_IDLE) ? ok_i    : ok_q;
    assign rmask_o = (state_q == S_IDLE) ? rmask_i : rmask_q;
endmodule

module mem_responder #(
    parameter int unsigned DEPTH     = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h1eceb000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus,
    output logic            err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [33:0] BYTE_LIMIT = 34'(DEPTH) << 2;

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    logic [31:0] mem_q [DEPTH];

    logic [31:0] i_off, d_off;
    logic        i_ok, d_ok, d_illegal, d_req;
    logic [3:0]  d_rmask_eff;

    assign i_off       = bus.imem_addr - BASE_ADDR;
    assign d_off       = bus.dmem_addr - BASE_ADDR;
    assign i_ok        = (bus.imem_addr >= BASE_ADDR) && ({2'b00, i_off} < BYTE_LIMIT);
    assign d_ok        = (bus.dmem_addr >= BASE_ADDR) && ({2'b00, d_off} < BYTE_LIMIT);
    assign d_illegal   = (|bus.dmem_rmask) && (|bus.dmem_wmask);
    assign d_req       = (|bus.dmem_rmask) || (|bus.dmem_wmask);
    // A read+write request is serviced as a write only.
    assign d_rmask_eff = d_illegal ? 4'h0 : bus.dmem_rmask;

    logic          i_accept, i_load, i_resp, i_ok_c;
    logic [AW-1:0] i_idx;
    logic [3:0]    i_rmask_c;
    logic          d_accept, d_load, d_resp, d_ok_c;
    logic [AW-1:0] d_idx;
    logic [3:0]    d_rmask_c;

    mem_responder_port #(.AW(AW), .LATENCY(LATENCY)) u_iport (
        .clk(clk), .rst_n(rst_n),
        .req_i(|bus.imem_rmask), .stall_i(bus.imem_stall),
        .idx_i(i_off[AW+1:2]), .ok_i(i_ok), .rmask_i(bus.imem_rmask),
        .accept_o(i_accept), .load_o(i_load), .resp_o(i_resp),
        .idx_o(i_idx), .ok_o(i_ok_c), .rmask_o(i_rmask_c)
    );

    mem_responder_port #(.AW(AW), .LATENCY(LATENCY)) u_dport (
        .clk(clk), .rst_n(rst_n),
        .req_i(d_req), .stall_i(bus.dmem_stall),
        .idx_i(d_off[AW+1:2]), .ok_i(d_ok), .rmask_i(d_rmask_eff),
        .accept_o(d_accept), .load_o(d_load), .resp_o(d_resp),
        .idx_o(d_idx), .ok_o(d_ok_c), .rmask_o(d_rmask_c)
    );

    logic [3:0]  d_wmask_q;
    logic [31:0] d_wdata_q;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic [31:0] i_word;
    logic        err_q, err_d;
    logic        d_we;

    assign d_we = d_resp && (|d_wmask_q) && d_ok_c;

    always_ff @(posedge clk) begin
        if (d_we) begin
            for (int b = 0; b < 4; b++) begin
                if (d_wmask_q[b]) mem_q[d_idx][8*b +: 8] <= d_wdata_q[8*b +: 8];
            end
        end
    end

    // An imem read landing on the edge that commits a dmem write sees the new bytes.
    always_comb begin
        i_word = mem_q[i_idx];
        if (d_we && (d_idx == i_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (d_wmask_q[b]) i_word[8*b +: 8] = d_wdata_q[8*b +: 8];
            end
        end
    end

    assign i_rdata_d = (i_ok_c ? i_word : 32'h0) & lane_mask(i_rmask_c);
    assign d_rdata_d = (d_ok_c ? mem_q[d_idx] : 32'h0) & lane_mask(d_rmask_c);
    assign err_d     = err_q || (i_accept && !i_ok) || (d_accept && (!d_ok || d_illegal));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_wmask_q <= '0;
            d_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (d_accept) begin
                d_wmask_q <= bus.dmem_wmask;
                d_wdata_q <= bus.dmem_wdata;
            end
            if (i_load) i_rdata_q <= i_rdata_d;
            if (d_load) d_rdata_q <= d_rdata_d;
            err_q <= err_d;
        end
    end

    assign bus.imem_rdata = i_rdata_q;
    assign bus.imem_resp  = i_resp;
    assign bus.dmem_rdata = d_rdata_q;
    assign bus.dmem_resp  = d_resp;
    assign err_o          = err_q;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Dual-port memory model that serves as the responder side of the cpu's instruction-memory and data-memory interfaces. The cpu is the initiator.
- Backed by a shared word array with a configurable, stallable response latency.
- Returns byte-lane-masked read data and applies byte-masked writes.
- Pulses resp for exactly one cycle per accepted request. Used as the memory for the scoreboard core in the bench and FPGA top.

Parameters:
- DEPTH, 16384: number of 32-bit words in the backing array (power of two).
- BASE_ADDR, 32'h1eceb000: byte address of word 0 (word-aligned).
- LATENCY, 2: cycles from request acceptance to resp when no stall is applied (>=1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- imem_addr  input  32  instruction byte address.
- imem_rmask  input  4  instruction read byte mask; nonzero means a request.
- imem_rdata  output  32  instruction read data.
- imem_resp  output  1  one-cycle instruction response pulse.
- imem_stall  input  1  while high, freezes the imem latency counter.
- dmem_addr  input  32  data byte address.
- dmem_rmask  input  4  data read byte mask.
- dmem_wmask  input  4  data write byte mask.
- dmem_wdata  input  32  data write data.
- dmem_rdata  output  32  data read data.
- dmem_resp  output  1  one-cycle data response pulse.
- dmem_stall  input  1  while high, freezes the dmem latency counter.
- err  output  1  sticky error flag.

Behaviour:
- Reset, asserted asynchronously:
  - imem_resp, dmem_resp, err, imem_rdata and dmem_rdata all go to 0.
  - Both port FSMs go to IDLE.
  - The backing array is NOT cleared.
  - A pending request is dropped, and a pending write is not performed.
- Per-port FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - A request is present when the mask is nonzero (imem: rmask; dmem: rmask or wmask).
  - On a present request, latch addr, masks and wdata; load counter with LATENCY-1; go to WAIT.
  - If LATENCY is 1, go directly to RESP on the next edge.
- WAIT:
  - Input changes are ignored; the latched request is used.
  - Counter decrements each cycle while stall is low and holds while stall is high.
  - At 0 with stall low, go to RESP.
- RESP:
  - resp=1 for exactly one cycle.
  - rdata holds the word read at that cycle, with bytes outside the latched rmask forced to 0.
  - A latched wmask writes the enabled bytes of the latched wdata at the end of the cycle.
  - Next state is IDLE.
  - rdata holds its value until the next RESP.
- Back-to-back requests:
  - In the cycle after RESP (IDLE), a still-present or new request is accepted.
  - Minimum spacing between responses is therefore LATENCY+1 cycles.
- Addressing:
  - index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
  - Out of range (addr < BASE_ADDR or index >= DEPTH): still respond, rdata=0, no write, set err.
- Illegal dmem request: rmask and wmask both nonzero sets err and is serviced as a write only (dmem_rdata=0).
- Collision:
  - imem RESP and dmem write RESP in the same cycle to the same word: imem returns the pre-write data (read-before-write).
  - dmem read after write to the same word: returns the new data.
- err clears only on reset.
- Timing: latency from the acceptance edge to the resp-high cycle equals LATENCY plus the number of stalled WAIT cycles.

Test Plan:
- Preload word0=32'hdeadbeef, LATENCY=2. imem_addr=BASE_ADDR, rmask=4'hf held -> imem_resp high exactly 2 cycles after acceptance, imem_rdata=32'hdeadbeef; next resp 3 cycles later.
- dmem write addr=BASE_ADDR+4, wmask=4'b0011, wdata=32'h12345678 over word=32'h0 -> after resp, a read with rmask=4'hf returns 32'h00005678.
- dmem read rmask=4'b1100 of 32'hdeadbeef -> dmem_rdata=32'hdead0000.
- dmem_stall high for 3 WAIT cycles at LATENCY=2 -> dmem_resp arrives 5 cycles after acceptance, width 1 cycle.
- Same-cycle imem read and dmem write (wdata=32'h0, wmask=4'hf) to word0 -> imem_rdata=32'hdeadbeef; a subsequent read returns 32'h0.
- addr=BASE_ADDR-4 -> resp with rdata=0 and err=1. Then drive rst low mid-WAIT on another request -> no resp, err=0, memory contents unchanged.
